axi_rd_arbiter: RTL and testbench

- 2:1 AXI4-Lite read-channel arbiter between the core's instruction-fetch master (m0) and load/store master (m1), and the single memory slave.
- Carries AR and R channels only; AW/W/B pass from m1 to the slave outside this block.
- One outstanding transaction at a time, round-robin grant, registered address.

---
 rtl/axi_rd_arbiter.sv | 114 +++++++++++
 tb/tb_axi_rd_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// 2:1 AXI4-Lite read-channel arbiter (AR + R) with round-robin grant.
// One transaction in flight; the address is registered and the R channel is a pass-through.
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e            state_q;
  logic              gnt_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;

  logic any_req;
  logic win;
  logic idle;

  always_comb begin
    any_req = m0_arvalid | m1_arvalid;
    // On a tie the master that was not served last wins.
    win     = (m0_arvalid && m1_arvalid) ? ~last_q : m1_arvalid;
    // arready is qualified with rst so every output is 0 while reset is asserted.
    idle    = rst && (state_q == IDLE);
  end

  always_comb begin
    m0_arready = idle && m0_arvalid && !win;
    m1_arready = idle && m1_arvalid && win;
    s_arvalid  = (state_q == ADDR);
    s_araddr   = addr_q;
  end

  always_comb begin
    m0_rvalid = 1'b0;
    m0_rdata  = '0;
    m0_rresp  = '0;
    m1_rvalid = 1'b0;
    m1_rdata  = '0;
    m1_rresp  = '0;
    s_rready  = 1'b0;
    if (state_q == DATA) begin
      if (gnt_q) begin
        s_rready  = m1_rready;
        m1_rvalid = s_rvalid;
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
      end else begin
        s_rready  = m0_rready;
        m0_rvalid = s_rvalid;
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            addr_q  <= win ? m1_araddr : m0_araddr;
            gnt_q   <= win;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (s_arready) state_q <= DATA;
        end
        DATA: begin
          if (s_rvalid && s_rready) begin
            last_q  <= gnt_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: grant table, directed corner sequences,
// and randomized traffic against a transaction-level round-robin model.
module tb_axi_rd_arbiter;

  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A1 = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m1_araddr, m1_rdata;
  logic [1:0]  m1_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [1:0]  s_rresp;

  int total = 0;
  int bad   = 0;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m0_arvalid = 0; m0_araddr = '0; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = '0; m1_rready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One quick transaction with a fully ready slave; leaves the DUT idle at a negedge.
  task automatic do_txn(input logic m, input logic [31:0] a);
    @(negedge clk);
    if (m) begin m1_arvalid = 1; m1_araddr = a; end
    else   begin m0_arvalid = 1; m0_araddr = a; end
    s_arready = 1; s_rvalid = 1; s_rdata = 32'h1234_5678; m0_rready = 1; m1_rready = 1;
    #1 chk("warm_accept", m ? m1_arready : m0_arready, 1);
    @(negedge clk);
    m0_arvalid = 0; m1_arvalid = 0;
    repeat (2) @(negedge clk);
    s_arready = 0; s_rvalid = 0; m0_rready = 0; m1_rready = 0;
  endtask

  typedef struct {
    int   warm;   // 0: straight from reset, 1: m0 served last, 2: m1 served last
    logic v0, v1;
    logic e0, e1;
  } vec_t;

  vec_t tbl[8];

  // Random-phase model state
  logic        ost, ap, dp, last_srv, em, any_r, w, gr, sl_req;
  logic        f_acc0, f_acc1, f_ar, f_r;
  logic [31:0] ea;
  logic        arv[2];
  int          sl_dly, done_n;

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 0, 1, 0};
    tbl[2] = '{0, 0, 1, 0, 1};
    tbl[3] = '{0, 1, 1, 1, 0};
    tbl[4] = '{1, 1, 1, 0, 1};
    tbl[5] = '{2, 1, 1, 1, 0};
    tbl[6] = '{1, 1, 0, 1, 0};
    tbl[7] = '{2, 0, 1, 0, 1};

    // Grant table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      if (tbl[i].warm != 0) do_txn(tbl[i].warm == 2, 32'h0000_0100);
      @(negedge clk);
      m0_arvalid = tbl[i].v0; m0_araddr = A0;
      m1_arvalid = tbl[i].v1; m1_araddr = A1;
      #1;
      chk($sformatf("tbl%0d_m0_arready", i), m0_arready, tbl[i].e0);
      chk($sformatf("tbl%0d_m1_arready", i), m1_arready, tbl[i].e1);
    end

    // Basic latency: accept at T, address at T+1, data at T+2
    do_reset();
    @(negedge clk);
    #1;
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_araddr", s_araddr, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    m0_arvalid = 1; m0_araddr = A0; s_arready = 1; m0_rready = 1;
    #1 chk("lat_m0_arready_T", m0_arready, 1);
    @(negedge clk);
    m0_arvalid = 0;
    #1;
    chk("lat_s_arvalid_T1", s_arvalid, 1);
    chk("lat_s_araddr_T1", s_araddr, A0);
    chk("lat_m1_rvalid_T1", m1_rvalid, 0);
    @(negedge clk);
    s_rvalid = 1; s_rdata = 32'h0000_0413; s_rresp = 2'b00;
    #1;
    chk("lat_m0_rvalid_T2", m0_rvalid, 1);
    chk("lat_m0_rdata_T2", m0_rdata, 32'h0000_0413);
    chk("lat_s_rready_T2", s_rready, 1);
    chk("lat_m1_rvalid_T2", m1_rvalid, 0);
    @(negedge clk);
    s_rvalid = 0; m0_rready = 0;
    #1 chk("lat_m0_rvalid_T3", m0_rvalid, 0);

    // Continuous requests from both: grants alternate m0, m1, m0, m1
    do_reset();
    @(negedge clk);
    m0_arvalid = 1; m0_araddr = A0; m1_arvalid = 1; m1_araddr = A1;
    s_arready = 1; s_rvalid = 1; s_rdata = 32'hCAFE_0001; m0_rready = 1; m1_rready = 1;
    begin
      int          k = 0;
      logic        chk_next = 0;
      logic [31:0] want_a = '0;
      for (int c = 0; c < 40 && (k < 4 || chk_next); c++) begin
        #1;
        if (chk_next) begin
          chk("alt_s_arvalid", s_arvalid, 1);
          chk("alt_s_araddr", s_araddr, want_a);
          chk_next = 0;
        end
        if (m0_arready || m1_arready) begin
          chk("alt_grant", m1_arready, k % 2);
          want_a   = m1_arready ? A1 : A0;
          chk_next = 1;
          k++;
        end
        @(negedge clk);
      end
      chk("alt_count", k, 4);
    end

    // Address stall, R backpressure and SLVERR pass-through on m1
    do_reset();
    @(negedge clk);
    m1_arvalid = 1; m1_araddr = 32'h8000_2000;
    #1 chk("st_m1_arready", m1_arready, 1);
    @(negedge clk);
    m1_arvalid = 0; m0_arvalid = 1; m0_araddr = A0; s_arready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("st_s_arvalid", s_arvalid, 1);
      chk("st_s_araddr", s_araddr, 32'h8000_2000);
      chk("st_arready", {m0_arready, m1_arready}, 0);
      @(negedge clk);
    end
    s_arready = 1;
    @(negedge clk);
    s_arready = 0; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b10; m1_rready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_s_rready", s_rready, 0);
      chk("bp_m1_rvalid", m1_rvalid, 1);
      chk("bp_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
      chk("bp_m1_rresp", m1_rresp, 2'b10);
      chk("bp_m0_rvalid", m0_rvalid, 0);
      chk("bp_m0_arready", m0_arready, 0);
      @(negedge clk);
    end
    m1_rready = 1;
    #1 chk("bp_s_rready_go", s_rready, 1);
    @(negedge clk);
    s_rvalid = 0; m1_rready = 0;
    #1 chk("bp_idle_m0_arready", m0_arready, 1);

    // Asynchronous reset during DATA
    do_reset();
    @(negedge clk);
    m0_arvalid = 1; m0_araddr = A0; s_arready = 1;
    @(negedge clk);
    m0_arvalid = 0;
    @(negedge clk);
    s_rvalid = 1; s_rdata = 32'h5555_AAAA; m0_rready = 0;
    m1_arvalid = 1; m1_araddr = A1;
    #1;
    chk("ar_m0_rvalid_pre", m0_rvalid, 1);
    chk("ar_m1_arready_pre", m1_arready, 0);
    #1 rst = 0;
    #1;
    chk("ar_m0_rvalid", m0_rvalid, 0);
    chk("ar_m0_rdata", m0_rdata, 0);
    chk("ar_s_rready", s_rready, 0);
    chk("ar_s_arvalid", s_arvalid, 0);
    chk("ar_s_araddr", s_araddr, 0);
    chk("ar_arready", {m0_arready, m1_arready}, 0);
    s_rvalid = 0; s_arready = 0;
    @(negedge clk);
    rst = 1;
    #1 chk("ar_m1_arready_post", m1_arready, 1);
    @(negedge clk);
    m1_arvalid = 0;
    #1;
    chk("ar_s_arvalid_post", s_arvalid, 1);
    chk("ar_s_araddr_post", s_araddr, A1);

    // Randomized traffic against a transaction-level model
    do_reset();
    ost = 0; ap = 0; dp = 0; last_srv = 1; em = 0; ea = '0; sl_req = 0; sl_dly = 0; done_n = 0;
    f_acc0 = 0; f_acc1 = 0; f_ar = 0; f_r = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (f_acc0) m0_arvalid = 0;
      if (f_acc1) m1_arvalid = 0;
      if (!m0_arvalid && ($urandom % 3 == 0)) begin m0_arvalid = 1; m0_araddr = $urandom & 32'hFFFF_FFFC; end
      if (!m1_arvalid && ($urandom % 3 == 0)) begin m1_arvalid = 1; m1_araddr = $urandom & 32'hFFFF_FFFC; end
      m0_rready = 1'($urandom % 2);
      m1_rready = 1'($urandom % 2);
      s_arready = 1'($urandom % 2);
      if (f_ar) begin sl_req = 1; sl_dly = int'($urandom % 3); end
      if (f_r) begin s_rvalid = 0; sl_req = 0; end
      if (sl_req && !s_rvalid) begin
        if (sl_dly == 0) begin
          s_rvalid = 1; s_rdata = $urandom; s_rresp = 2'($urandom % 4);
        end else sl_dly--;
      end
      if (!s_rvalid) s_rdata = $urandom;
      #1;
      f_acc0 = 0; f_acc1 = 0; f_ar = 0; f_r = 0;
      arv[0] = m0_arvalid; arv[1] = m1_arvalid;
      if (!ost) begin
        any_r = arv[0] | arv[1];
        // Preferred master is the one not served last; fall back to the other.
        w = arv[!last_srv] ? !last_srv : last_srv;
        chk("rnd_m0_arready", m0_arready, any_r && (w == 0));
        chk("rnd_m1_arready", m1_arready, any_r && (w == 1));
        if (any_r) begin f_acc0 = (w == 0); f_acc1 = (w == 1); end
      end else begin
        chk("rnd_busy_arready", {m0_arready, m1_arready}, 0);
      end
      chk("rnd_s_arvalid", s_arvalid, ap);
      if (ap) begin
        chk("rnd_s_araddr", s_araddr, ea);
        if (s_arready) f_ar = 1;
      end
      gr = em ? m1_rready : m0_rready;
      chk("rnd_s_rready", s_rready, dp && gr);
      chk("rnd_m0_rvalid", m0_rvalid, dp && !em && s_rvalid);
      chk("rnd_m1_rvalid", m1_rvalid, dp && em && s_rvalid);
      if (dp && s_rvalid) begin
        chk("rnd_rdata", em ? m1_rdata : m0_rdata, s_rdata);
        chk("rnd_rresp", em ? m1_rresp : m0_rresp, s_rresp);
        chk("rnd_other_rdata", em ? m0_rdata : m1_rdata, 0);
        if (gr) f_r = 1;
      end
      if (f_ar) begin ap = 0; dp = 1; end
      if (f_r) begin dp = 0; ost = 0; last_srv = em; done_n++; end
      if (f_acc0 || f_acc1) begin
        ost = 1; ap = 1; em = f_acc1;
        ea = f_acc1 ? m1_araddr : m0_araddr;
      end
    end
    chk("rnd_progress", (done_n >= 100) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
